// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer producing HI/LO.
// One 32-bit adder/subtractor is reused over 32 CALC cycles
// (shift-add multiply, restoring divide).
// Optional feature macro: MDU_EARLY_OUT_EN adds a zero-operand shortcut from PREP to DONE.
// Status and result outputs are registered from the state, so done rises one
// cycle after the FSM enters DONE.
module mdu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi_out;
    logic [WIDTH-1:0]   r_lo_out;

    logic               w_accept;
    logic               w_is_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_a_zero;
    logic               w_b_zero;
    logic               w_early;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic               w_no_borrow;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic               w_busy_d;
    logic               w_done_d;

    // A start is taken only in IDLE and not during the trailing done cycle
    assign w_accept = (r_state == S_IDLE) && i_start && !r_busy;
    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_a_zero = (r_a == '0);
    assign w_b_zero = (r_b == '0);
    assign w_a_mag  = (w_signed && r_a[WIDTH-1]) ? (~r_a + WIDTH'(1)) : r_a;
    assign w_b_mag  = (w_signed && r_b[WIDTH-1]) ? (~r_b + WIDTH'(1)) : r_b;

`ifdef MDU_EARLY_OUT_EN
    assign w_early = w_is_div ? (w_a_zero && !w_b_zero) : (w_a_zero || w_b_zero);
`else
    assign w_early = 1'b0;
`endif

    // Shared adder: add multiplicand for MUL, subtract divisor for DIV (unsigned)
    assign w_rem_sh = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_sub    = w_is_div;
    assign w_add_a  = w_is_div ? w_rem_sh : r_hi;
    assign w_add_b  = w_is_div ? r_b : (r_lo[0] ? r_a : '0);
    assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b ^ {WIDTH{w_sub}}} + (WIDTH+1)'(w_sub);
    // The bit shifted out of rem acts as bit 32 of the partial remainder
    assign w_no_borrow = w_sum[WIDTH] | r_hi[WIDTH-1];
    assign w_prod_neg  = ~{r_hi, r_lo} + (2*WIDTH)'(1);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_PREP;
            S_PREP: begin
                if ((w_is_div && w_b_zero) || w_early) w_state_nxt = S_DONE;
                else                                    w_state_nxt = S_CALC;
            end
            S_CALC: if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode feeding the status registers
    always_comb begin
        w_busy_d = 1'b0;
        w_done_d = 1'b0;
        if ((w_state_nxt != S_IDLE) || (r_state == S_DONE)) w_busy_d = 1'b1;
        if (r_state == S_DONE)                               w_done_d = 1'b1;
    end

    // Working datapath: operand capture, sign handling, iterations, fix-up
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= i_op;
                        r_a  <= i_a;
                        r_b  <= i_b;
                    end
                end
                S_PREP: begin
                    r_cnt    <= '0;
                    r_dz     <= 1'b0;
                    r_sign_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_sign_r <= w_signed & r_a[WIDTH-1];
                    if (w_is_div && w_b_zero) begin
                        r_dz <= 1'b1;
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (w_early) begin
                        r_hi <= '0;
                        r_lo <= '0;
                    end else if (w_is_div) begin
                        r_hi <= '0;
                        r_lo <= w_a_mag;
                        r_b  <= w_b_mag;
                    end else begin
                        r_hi <= '0;
                        r_lo <= w_b_mag;
                        r_a  <= w_a_mag;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_is_div) begin
                        r_hi <= w_no_borrow ? w_sum[WIDTH-1:0] : w_rem_sh;
                        r_lo <= {r_lo[WIDTH-2:0], w_no_borrow};
                    end else begin
                        r_hi <= w_sum[WIDTH:1];
                        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (w_signed) begin
                        if (w_is_div) begin
                            if (r_sign_q) r_lo <= ~r_lo + WIDTH'(1);
                            if (r_sign_r) r_hi <= ~r_hi + WIDTH'(1);
                        end else if (r_sign_q) begin
                            r_hi <= w_prod_neg[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_neg[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status and result outputs, results captured out of DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi_out   <= '0;
            r_lo_out   <= '0;
        end else begin
            r_busy <= w_busy_d;
            r_done <= w_done_d;
            if (r_state == S_DONE) begin
                r_div_zero <= r_dz;
                r_hi_out   <= r_hi;
                r_lo_out   <= r_lo;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
    assign o_hi       = r_hi_out;
    assign o_lo       = r_lo_out;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS integer core. Implements MULT, MULTU, DIV and DIVU and produces results in HI/LO.
- Time-multiplexes one instance of the team's 32-bit adder/subtractor block over 32 iteration cycles instead of a combinational array.
- Sits beside the ALU in EX. The pipeline stalls on busy and latches HI/LO on done.

Parameters:
- WIDTH, 32, operand/result width. Fixed at 32; the adder block is 32-bit.
- ITER, 32, iteration count in CALC. Must equal WIDTH.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  32  multiplicand / dividend
- B  in  32  multiplier / divisor
- busy  out  1  high from the cycle after start acceptance through the DONE cycle
- done  out  1  one-cycle pulse; hi/lo valid from this cycle on
- div_zero  out  1  valid with done; 1 iff DIV/DIVU with B==0
- hi  out  32  MUL: product[63:32]; DIV: remainder
- lo  out  32  MUL: product[31:0]; DIV: quotient

Behaviour:
- Reset:
  - Takes effect at any state, including mid-operation.
  - Next state is IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; all working registers cleared.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - If start=1, latch op, A and B; go to PREP.
  - Otherwise hold.
- PREP (1 cycle):
  - Signed ops: convert operands to magnitudes and record result signs.
    - MUL: sign = A[31]^B[31].
    - DIV: quotient sign = A[31]^B[31]; remainder sign = A[31].
  - Unsigned ops: operands pass unchanged.
  - DIV/DIVU with B==0: go directly to DONE; div_zero=1, lo=32'hFFFF_FFFF, hi=A.
  - Otherwise go to CALC with iteration counter = 0.
- CALC (exactly ITER cycles, counter 0..31):
  - The shared adder always runs in unsigned mode (Sign=0): V = carry-out on add, borrow on subtract.
  - MUL (shift-add):
    - If the multiplier LSB is 1, add the multiplicand to the upper partial product (ctrl=0).
    - Shift {carry, upper, lower} right by 1.
  - DIV (restoring):
    - Shift {rem, quo} left by 1, then subtract the divisor from rem (ctrl=1).
    - If borrow=0: keep the difference and set quo LSB=1.
    - Otherwise: keep rem and set quo LSB=0.
  - Leave CALC when counter==31.
- FIX (1 cycle):
  - Signed MUL: negate the 64-bit product if sign=1.
  - Signed DIV: negate the quotient and the remainder per their recorded signs.
- DONE (1 cycle):
  - done=1, busy=1; hi/lo registers updated on entry.
  - Next state IDLE.
- Latency:
  - Start sampled at edge k; done high in the cycle following edge k+35.
  - The zero-divisor path finishes in the cycle following edge k+2.
- hi/lo/div_zero hold their values until the next DONE. div_zero is rewritten at every DONE.
- start while busy is ignored; there is no queueing.
- Signed DIV of 32'h8000_0000 by 32'hFFFF_FFFF gives lo=32'h8000_0000, hi=0. No trap.
- op, A and B are ignored after acceptance; changes to them do not affect the operation in flight.

Optional Feature:
- MDU_EARLY_OUT_EN, when defined, adds a zero-operand shortcut:
  - MUL with A==0 or B==0: go PREP -> DONE with hi=lo=0.
  - DIV with A==0 and B!=0: go PREP -> DONE with hi=lo=0.
  - These cases finish with done high in the cycle following edge k+2.
- Undefined: those cases take the full CALC path and 35-edge latency. Results are identical either way.

Test Plan:
- MULT A=32'hFFFF_FFFD (-3), B=5 -> done at edge k+35; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1, div_zero=0.
- MULTU A=B=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV A=32'hFFFF_FFF9 (-7), B=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
- DIVU A=32'h1234_5678, B=0 -> done at edge k+2; div_zero=1, lo=32'hFFFF_FFFF, hi=32'h1234_5678.
- DIVU A=100, B=7 -> lo=14, hi=2. A second start pulse at cycle 10 is ignored: exactly one done, busy continuous.
- MULTU 3*4 started, rst=1 at cycle 20 -> next edge busy=0, done=0, hi=lo=0. A new MULTU 3*4 then yields lo=12, hi=0.
